// File: rtl/fetch_stage_if.sv
// Fetch-side bus: instruction memory read port plus the
// valid/ready hand-off of {pc, inst} towards decode.
interface fetch_stage_if #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16
);
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_rd_addr;
  logic [INST_W-1:0] imem_rd_data;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic              id_ready;

  modport master (
    output imem_rd_en,
    output imem_rd_addr,
    input  imem_rd_data,
    output if_valid,
    output if_inst,
    output if_pc,
    input  id_ready
  );

  modport slave (
    input  imem_rd_en,
    input  imem_rd_addr,
    output imem_rd_data,
    input  if_valid,
    input  if_inst,
    input  if_pc,
    output id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC owner, 1-cycle imem reads, 2-entry
// skid FIFO towards decode, redirect flush and halt/drain.
module fetch_stage #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted,
  fetch_stage_if.master     bus
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] tag;
  logic              inflight;
  logic [1:0]        count;
  logic [1:0]        count_n;

  logic [ADDR_W-1:0] pc0;
  logic [ADDR_W-1:0] pc1;
  logic [INST_W-1:0] in0;
  logic [INST_W-1:0] in1;
  logic [ADDR_W-1:0] pc0_n;
  logic [ADDR_W-1:0] pc1_n;
  logic [INST_W-1:0] in0_n;
  logic [INST_W-1:0] in1_n;

  logic       pop;
  logic       push;
  logic       issue;
  logic       wslot;
  logic [2:0] occ;

  assign bus.if_valid = ~rst & (count != 2'd0);
  assign bus.if_pc    = rst ? '0 : pc0;
  assign bus.if_inst  = rst ? '0 : in0;

  assign pop  = bus.if_valid & bus.id_ready;
  assign push = inflight & ~redirect_valid;

  // occupancy after this cycle's pop, counting the read in flight
  assign occ = {1'b0, count}
             + {2'b00, inflight}
             - {2'b00, pop};

  assign issue = (state == RUN)
               & ~redirect_valid
               & ~rst
               & (occ < 3'd2);

  assign bus.imem_rd_en   = issue;
  assign bus.imem_rd_addr = pc;

  assign halted = ~rst & (state == HALTED);

  // a push lands in slot 1 only if the head stays put
  assign wslot = count[0] & ~pop;

  always_comb begin
    pc0_n = pc0;
    pc1_n = pc1;
    in0_n = in0;
    in1_n = in1;
    if (pop) begin
      pc0_n = pc1;
      in0_n = in1;
    end
    if (push) begin
      if (wslot) begin
        pc1_n = tag;
        in1_n = bus.imem_rd_data;
      end else begin
        pc0_n = tag;
        in0_n = bus.imem_rd_data;
      end
    end
  end

  always_comb begin
    count_n = count
            + {1'b0, push}
            - {1'b0, pop};
  end

  always_comb begin
    pc_n = pc;
    if (redirect_valid) begin
      pc_n = redirect_pc;
    end else if (issue) begin
      pc_n = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_n = state;
    if (redirect_valid) begin
      state_n = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_req) state_n = DRAIN;
        end
        DRAIN: begin
          if (!halt_req) begin
            state_n = RUN;
          end else if (!inflight
                       && count_n == 2'd0) begin
            state_n = HALTED;
          end
        end
        HALTED: begin
          if (!halt_req) state_n = RUN;
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      count    <= 2'd0;
      pc0      <= '0;
      pc1      <= '0;
      in0      <= '0;
      in1      <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      inflight <= issue;
      if (issue) tag <= pc;
      count    <= redirect_valid ? 2'd0 : count_n;
      pc0      <= pc0_n;
      pc1      <= pc1_n;
      in0      <= in0_n;
      in1      <= in1_n;
    end
  end

  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst)
    ({1'b0, count} + {2'b00, inflight}) <= 3'd2
  );

endmodule
